// File: rtl/gt_tx_framer.sv
// rtl/gt_tx_framer.sv - GT TX framer: header, payload, checksum tail and K28.5 idle fill
// Output word and K flags are registered; the frame FSM selects their next value.
module gt_tx_framer #(
  parameter int         FRAME_LEN = 16,
  parameter logic [7:0] IDLE_CHAR = 8'hBC
) (
  input  logic         gt_clk,
  input  logic         gt_rst,
  input  logic         enable,
  input  logic [191:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [191:0] tx_data,
  output logic [23:0]  tx_charisk,
  output logic [15:0]  frame_cnt,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  localparam logic [7:0]   LAST_IDX  = 8'(FRAME_LEN - 1);
  localparam logic [191:0] IDLE_WORD = {24{IDLE_CHAR}};

  logic [1:0]   state_q, state_d;
  logic [191:0] tx_data_q, tx_data_d;
  logic [23:0]  tx_charisk_q, tx_charisk_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic [31:0]  chk_q, chk_d;
  logic [7:0]   wcnt_q, wcnt_d;
  logic [31:0]  lane_x;

  always_comb begin
    lane_x = '0;
    for (int k = 0; k < 6; k++) begin
      lane_x = lane_x ^ s_data[32*k +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    chk_d        = chk_q;
    wcnt_d       = wcnt_q;
    tx_data_d    = IDLE_WORD;
    tx_charisk_d = 24'hFFFFFF;
    case (state_q)
      S_IDLE: begin
        if (enable && s_valid) begin
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        state_d      = S_PAY;
        chk_d        = '0;
        wcnt_d       = '0;
        tx_data_d    = {160'h0, LAST_IDX, frame_cnt_q, 8'hFB};
        tx_charisk_d = 24'h000001;
      end
      S_PAY: begin
        // Without s_valid the idle word is sent as fill and the frame state holds.
        if (s_valid) begin
          tx_data_d    = s_data;
          tx_charisk_d = 24'h000000;
          chk_d        = chk_q ^ lane_x;
          wcnt_d       = wcnt_q + 8'd1;
          if (wcnt_q == LAST_IDX) begin
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        state_d      = S_IDLE;
        frame_cnt_d  = frame_cnt_q + 16'd1;
        tx_data_d    = {152'h0, 8'hFD, chk_q};
        tx_charisk_d = 24'h000010;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge gt_clk or posedge gt_rst) begin
    if (gt_rst) begin
      state_q      <= S_IDLE;
      tx_data_q    <= IDLE_WORD;
      tx_charisk_q <= 24'hFFFFFF;
      frame_cnt_q  <= '0;
      chk_q        <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_charisk_q <= tx_charisk_d;
      frame_cnt_q  <= frame_cnt_d;
      chk_q        <= chk_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign s_ready    = (state_q == S_PAY);
  assign busy       = (state_q != S_IDLE);
  assign tx_data    = tx_data_q;
  assign tx_charisk = tx_charisk_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_gt_tx_framer.sv
// tb/tb_gt_tx_framer.sv - bench for gt_tx_framer
// Three instances (FRAME_LEN 4, 2, 16) share stimulus; each scenario checks one of them.
module tb_gt_tx_framer;

  logic         gt_clk = 1'b0;
  logic         gt_rst;
  logic         enable;
  logic [191:0] s_data;
  logic         s_valid;

  logic         r4, r2, r16, b4, b2, b16;
  logic [191:0] tx4, tx2, tx16;
  logic [23:0]  ck4, ck2, ck16;
  logic [15:0]  fc4, fc2, fc16;

  int errors = 0;
  int checks = 0;

  localparam logic [191:0] IDLE_W = {24{8'hBC}};

  always #5 gt_clk = ~gt_clk;

  gt_tx_framer #(.FRAME_LEN(4)) u4 (
    .gt_clk(gt_clk), .gt_rst(gt_rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(r4), .tx_data(tx4), .tx_charisk(ck4), .frame_cnt(fc4), .busy(b4));
  gt_tx_framer #(.FRAME_LEN(2)) u2 (
    .gt_clk(gt_clk), .gt_rst(gt_rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(r2), .tx_data(tx2), .tx_charisk(ck2), .frame_cnt(fc2), .busy(b2));
  gt_tx_framer #(.FRAME_LEN(16)) u16 (
    .gt_clk(gt_clk), .gt_rst(gt_rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(r16), .tx_data(tx16), .tx_charisk(ck16), .frame_cnt(fc16), .busy(b16));

  typedef struct {
    logic         en;
    logic         vld;
    logic [191:0] data;
    logic [191:0] exp_data;
    logic [23:0]  exp_k;
    logic         exp_busy;
  } vec_t;

  vec_t vt[10];

  function automatic logic [191:0] w6(input logic [31:0] x);
    return {6{x}};
  endfunction

  function automatic logic [191:0] lane0(input logic [31:0] x);
    return {160'h0, x};
  endfunction

  function automatic logic [191:0] hdr(input logic [15:0] fc, input logic [7:0] len1);
    return {160'h0, len1, fc, 8'hFB};
  endfunction

  function automatic logic [191:0] tl(input logic [31:0] c);
    return {152'h0, 8'hFD, c};
  endfunction

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gt_clk);
    #1;
  endtask

  task automatic do_reset();
    gt_rst  = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    step();
    gt_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npay;
    int tail_at;

    gt_rst  = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #7;
    check("rst_tx_data", tx4, IDLE_W);
    check("rst_charisk", 192'(ck4), 192'(24'hFFFFFF));
    check("rst_frame_cnt", 192'(fc4), 192'(16'h0));
    check("rst_busy", 192'(b4), 192'(1'b0));
    check("rst_s_ready", 192'(r4), 192'(1'b0));
    step();
    gt_rst = 1'b0;

    // Idle with enable and no data, then one FRAME_LEN=4 frame with lanes of word i = i+1.
    vt[0] = '{1'b1, 1'b0, '0,     IDLE_W,         24'hFFFFFF, 1'b0};
    vt[1] = '{1'b1, 1'b0, '0,     IDLE_W,         24'hFFFFFF, 1'b0};
    vt[2] = '{1'b1, 1'b1, w6(1),  IDLE_W,         24'hFFFFFF, 1'b1};
    vt[3] = '{1'b1, 1'b1, w6(1),  hdr(16'h0, 8'd3), 24'h000001, 1'b1};
    vt[4] = '{1'b1, 1'b1, w6(1),  w6(1),          24'h000000, 1'b1};
    vt[5] = '{1'b1, 1'b1, w6(2),  w6(2),          24'h000000, 1'b1};
    vt[6] = '{1'b1, 1'b1, w6(3),  w6(3),          24'h000000, 1'b1};
    vt[7] = '{1'b1, 1'b1, w6(4),  w6(4),          24'h000000, 1'b1};
    vt[8] = '{1'b0, 1'b0, '0,     tl(32'h0),      24'h000010, 1'b0};
    vt[9] = '{1'b0, 1'b0, '0,     IDLE_W,         24'hFFFFFF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      enable  = vt[i].en;
      s_valid = vt[i].vld;
      s_data  = vt[i].data;
      step();
      check($sformatf("vec%0d_data", i), tx4, vt[i].exp_data);
      check($sformatf("vec%0d_k", i), 192'(ck4), 192'(vt[i].exp_k));
      check($sformatf("vec%0d_busy", i), 192'(b4), 192'(vt[i].exp_busy));
    end
    check("vec_frame_cnt", 192'(fc4), 192'(16'd1));

    // FRAME_LEN=2 checksum across lanes and words
    do_reset();
    enable = 1'b1; s_valid = 1'b1;
    s_data = lane0(32'hA5A5A5A5);
    step(); step(); step();
    s_data = {64'h0, 32'h0F0F0000, 96'h0};
    step();
    enable = 1'b0; s_valid = 1'b0;
    step();
    check("len2_checksum", 192'(tx2[31:0]), 192'(32'hAAAAA5A5));
    check("len2_tail_k", 192'(tx2[39:32]), 192'(8'hFD));
    check("len2_tail_charisk", 192'(ck2), 192'(24'h000010));

    // FRAME_LEN=4 with three fill cycles after the second payload word
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_data = lane0(1);
    step(); step();
    check("fill_header", tx4, hdr(16'h0, 8'd3));
    step();
    s_data = lane0(2);
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fill%0d_data", i), tx4, IDLE_W);
      check($sformatf("fill%0d_ready", i), 192'(r4), 192'(1'b1));
      check($sformatf("fill%0d_busy", i), 192'(b4), 192'(1'b1));
    end
    s_valid = 1'b1; s_data = lane0(3);
    step();
    check("fill_word3", tx4, lane0(3));
    s_data = lane0(4);
    step();
    check("fill_word4", tx4, lane0(4));
    enable = 1'b0; s_valid = 1'b0;
    step();
    check("fill_tail", tx4, tl(32'h4));
    check("fill_frame_cnt", 192'(fc4), 192'(16'd1));

    // FRAME_LEN=16, enable dropped during the first payload word
    do_reset();
    enable = 1'b1; s_valid = 1'b1; s_data = lane0(1);
    step(); step();
    check("en_drop_header", tx16, hdr(16'h0, 8'd15));
    enable = 1'b0;
    npay = 0;
    tail_at = -1;
    for (int i = 0; i < 40 && tail_at < 0; i++) begin
      s_data = lane0(32'(i + 1));
      step();
      if (ck16 == 24'h000000) npay++;
      if (ck16 == 24'h000010) tail_at = i;
    end
    check("en_drop_tail_seen", 192'(tail_at), 192'(16));
    check("en_drop_payload_words", 192'(npay), 192'(16));
    check("en_drop_checksum", 192'(tx16[31:0]), 192'(32'h10));
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("en_drop_idle%0d", i), tx16, IDLE_W);
      check($sformatf("en_drop_busy%0d", i), 192'(b16), 192'(1'b0));
    end
    check("en_drop_frame_cnt", 192'(fc16), 192'(16'd1));

    // Reset pulsed during the 5th payload word of a FRAME_LEN=16 frame
    enable = 1'b1; s_valid = 1'b1; s_data = lane0(1);
    step(); step();
    check("rst_mid_header1", tx16, hdr(16'd1, 8'd15));
    for (int i = 0; i < 4; i++) begin
      s_data = lane0(32'(i + 1));
      step();
    end
    s_data = lane0(5);
    #2;
    gt_rst = 1'b1;
    #1;
    check("rst_mid_tx_data", tx16, IDLE_W);
    check("rst_mid_charisk", 192'(ck16), 192'(24'hFFFFFF));
    check("rst_mid_frame_cnt", 192'(fc16), 192'(16'd0));
    check("rst_mid_busy", 192'(b16), 192'(1'b0));
    check("rst_mid_ready", 192'(r16), 192'(1'b0));
    #1;
    gt_rst = 1'b0;
    step();
    check("rst_mid_first_out", tx16, IDLE_W);
    step();
    check("rst_mid_header0", tx16, hdr(16'd0, 8'd15));

    // frame_cnt wrap from 16'hFFFF
    do_reset();
    force u4.frame_cnt_q = 16'hFFFF;
    enable = 1'b1; s_valid = 1'b1; s_data = lane0(7);
    step();
    release u4.frame_cnt_q;
    step();
    check("wrap_header_cnt", 192'(tx4[23:8]), 192'(16'hFFFF));
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0; s_valid = 1'b0;
    step();
    check("wrap_tail_charisk", 192'(ck4), 192'(24'h000010));
    check("wrap_frame_cnt", 192'(fc4), 192'(16'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
